aes_gcm_input_sequencer: RTL and testbench
==========================================

# aes_gcm_input_sequencer

Schedules one AES-GCM instance at a time into the 128-bit block pipeline register stage that carries plain text, AAD, instance size and a valid signal. It accepts a length descriptor, then pulls AAD blocks followed by text blocks from a single input stream. It masks partial final blocks and appends the GCM length block len(A)||len(C). It presents the result as a registered, back-pressurable beat stream in front of the pipeline stage.

## Interface
- LEN_W, 32: width of byte-length fields; legal 8..61
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_desc_valid  in  1  descriptor offered
- o_desc_ready  out  1  descriptor accepted when both high
- i_aad_len  in  LEN_W  AAD length in bytes
- i_text_len  in  LEN_W  plain-text length in bytes
- i_data  in  [0:127]  input block; byte 0 = bits 0:7
- i_data_valid  in  1  input block offered
- o_data_ready  out  1  input block accepted when both high
- o_signal  out  1  output beat valid
- i_ready  in  1  downstream accepts beat when o_signal && i_ready
- o_aad  out  [0:127]  AAD block (zero on non-AAD beats)
- o_plain_text  out  [0:127]  text block (zero on non-text beats)
- o_instance_size  out  [0:127]  {len(A) bits, 64b ; len(C) bits, 64b}, constant for the instance
- o_kind  out  2  beat type: 0 AAD, 1 TEXT, 2 LEN
- o_last  out  1  high on the LEN beat only

## Operation
- FSM states: IDLE, AAD, TEXT, LEN.
- IDLE: o_desc_ready=1 only here. On descriptor handshake, latch the lengths and compute:
  - blocks = (len+15)>>4, width LEN_W-3
  - bits = len<<3, zero-extended to 64
  - the instance_size register
- From IDLE, go to AAD if aad blocks>0, else TEXT if text blocks>0, else LEN.
- AAD/TEXT:
  - Each input handshake loads the output register with the block and kind, and decrements the remaining count.
  - When the final block of a phase is accepted, advance to the next phase, skipping TEXT if its count is 0.
- Partial final block: for rem = len mod 16 ≠ 0, bytes rem..15 are forced to zero. Full blocks pass unmodified.
- LEN: when the output register is free, load a beat with o_kind=2, o_last=1, and o_aad/o_plain_text zero, then return to IDLE.
- The output register holds all o_* stable while o_signal && !i_ready.
- Input data presented in IDLE or LEN is not consumed.

## Timing
- Reset values: o_signal, o_last, o_kind, o_aad, o_plain_text, o_instance_size all 0; o_desc_ready=1 (IDLE); o_data_ready=0; counters 0.
- o_data_ready = (state is AAD or TEXT) && (!o_signal || i_ready). It is combinational from state and i_ready.
- Latency: input handshake at edge N, so the beat is visible from edge N on. Each beat is registered exactly once.
- Throughput is 1 beat/cycle with i_ready held high. An instance with a AAD and t text blocks takes a+t+1 output beats.
- The LEN beat follows the last data beat on the next cycle when i_ready=1.
- o_desc_ready rises in the cycle after the LEN beat is loaded. The next descriptor can be accepted then, but is not accepted in the same cycle as the LEN load.
- Deasserting rst_n at any time returns to IDLE immediately. A partially sent instance is abandoned with no LEN beat.

## Configuration
- AES_GCM_SEQ_PERF_EN defined:
  - Adds o_inst_count (out, 32): increments on each LEN-beat handshake.
  - Adds o_stall_count (out, 32): increments each cycle with o_signal && !i_ready.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package aes_gcm_pkg: block_t (logic [0:127]), beat-kind enum (AAD=0, TEXT=1, LEN=2), FSM state enum, function mask_tail(block, rem).
- No sub-module. The output register is inline; the FSM and counters live in one module.

## Test plan
- aad_len=16, text_len=32, i_ready=1 → beats AAD, TEXT, TEXT, LEN on 4 consecutive cycles; o_instance_size = 0x80 in the upper 64b and 0x100 in the lower 64b.
- aad_len=0, text_len=20 → TEXT, TEXT, LEN. Bytes 4..15 of the second text block are zero even if i_data bytes are 0xFF. o_instance_size = {0, 160}.
- aad_len=0, text_len=0 → a single LEN beat with o_instance_size=0 and o_last=1. o_data_ready stays 0 throughout.
- i_ready held low for 5 cycles mid-text → outputs stable, o_data_ready=0, no beat lost or duplicated. With AES_GCM_SEQ_PERF_EN, o_stall_count=5.
- rst_n pulsed low after 1 of 3 text beats → all outputs return to reset values asynchronously. The next descriptor then runs to a normal LEN beat, and o_inst_count counts only that instance.

Source files
------------

// File: rtl/aes_gcm_pkg.sv
// Shared types for the AES-GCM input sequencer: block type, beat kinds,
// FSM states and the partial-block tail mask.
package aes_gcm_pkg;

    typedef logic [0:127] block_t;

    typedef enum logic [1:0] {
        KIND_AAD  = 2'd0,
        KIND_TEXT = 2'd1,
        KIND_LEN  = 2'd2
    } beat_kind_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AAD,
        S_TEXT,
        S_LEN
    } state_e;

    // Zero bytes rem..15 of a block; rem == 0 means the block is full.
    function automatic block_t mask_tail(input block_t blk, input logic [3:0] rem);
        block_t r;
        r = blk;
        if (rem != 4'd0) begin
            for (int b = 0; b < 16; b++) begin
                if (b >= int'(rem)) begin
                    r[8*b +: 8] = 8'h00;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_gcm_input_sequencer.sv
// Sequences one AES-GCM instance (AAD blocks, text blocks, length block) into a
// registered back-pressurable beat stream. Optional counters: AES_GCM_SEQ_PERF_EN.
module aes_gcm_input_sequencer
    import aes_gcm_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_desc_valid,
    output logic             o_desc_ready,
    input  logic [LEN_W-1:0] i_aad_len,
    input  logic [LEN_W-1:0] i_text_len,
    input  logic [0:127]     i_data,
    input  logic             i_data_valid,
    output logic             o_data_ready,
    output logic             o_signal,
    input  logic             i_ready,
    output logic [0:127]     o_aad,
    output logic [0:127]     o_plain_text,
    output logic [0:127]     o_instance_size,
    output logic [1:0]       o_kind,
    output logic             o_last
`ifdef AES_GCM_SEQ_PERF_EN
    ,
    output logic [31:0]      o_inst_count,
    output logic [31:0]      o_stall_count
`endif
);

    localparam int CNT_W = LEN_W - 3;

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_aad_cnt;
    logic [CNT_W-1:0] r_text_cnt;
    logic [3:0]       r_aad_rem;
    logic [3:0]       r_text_rem;
    block_t           r_inst_size;

    logic             r_signal;
    beat_kind_e       r_kind;
    logic             r_last;
    block_t           r_aad;
    block_t           r_plain;
    block_t           r_size_out;

    logic             w_out_free;
    logic             w_desc_hs;
    logic             w_data_hs;
    logic [LEN_W:0]   w_aad_sum;
    logic [LEN_W:0]   w_text_sum;
    logic [CNT_W-1:0] w_aad_blocks;
    logic [CNT_W-1:0] w_text_blocks;
    logic             w_is_final;
    logic [3:0]       w_rem;
    block_t           w_block;

    assign w_out_free   = !r_signal || i_ready;
    assign o_desc_ready = (r_state == S_IDLE);
    assign o_data_ready = ((r_state == S_AAD) || (r_state == S_TEXT)) && w_out_free;
    assign w_desc_hs    = i_desc_valid && o_desc_ready;
    assign w_data_hs    = i_data_valid && o_data_ready;

    // Block count = ceil(len/16); the extra sum bit keeps the carry of len+15.
    assign w_aad_sum     = {1'b0, i_aad_len} + (LEN_W+1)'(15);
    assign w_text_sum    = {1'b0, i_text_len} + (LEN_W+1)'(15);
    assign w_aad_blocks  = w_aad_sum[LEN_W:4];
    assign w_text_blocks = w_text_sum[LEN_W:4];

    assign w_is_final = (r_state == S_AAD) ? (r_aad_cnt == CNT_W'(1)) : (r_text_cnt == CNT_W'(1));
    assign w_rem      = (r_state == S_AAD) ? r_aad_rem : r_text_rem;
    assign w_block    = w_is_final ? mask_tail(i_data, w_rem) : i_data;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_desc_hs) begin
                    if (w_aad_blocks != '0)       w_state_next = S_AAD;
                    else if (w_text_blocks != '0) w_state_next = S_TEXT;
                    else                          w_state_next = S_LEN;
                end
            end
            S_AAD: begin
                if (w_data_hs && (r_aad_cnt == CNT_W'(1))) begin
                    w_state_next = (r_text_cnt != '0) ? S_TEXT : S_LEN;
                end
            end
            S_TEXT: begin
                if (w_data_hs && (r_text_cnt == CNT_W'(1))) w_state_next = S_LEN;
            end
            S_LEN: begin
                if (w_out_free) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_aad_cnt   <= '0;
            r_text_cnt  <= '0;
            r_aad_rem   <= '0;
            r_text_rem  <= '0;
            r_inst_size <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_desc_hs) begin
                r_aad_cnt   <= w_aad_blocks;
                r_text_cnt  <= w_text_blocks;
                r_aad_rem   <= i_aad_len[3:0];
                r_text_rem  <= i_text_len[3:0];
                r_inst_size <= {64'(i_aad_len) << 3, 64'(i_text_len) << 3};
            end else if (w_data_hs) begin
                if (r_state == S_AAD) r_aad_cnt  <= r_aad_cnt - CNT_W'(1);
                else                  r_text_cnt <= r_text_cnt - CNT_W'(1);
            end
        end
    end

    // Output register: holds while a beat is offered and not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_signal   <= 1'b0;
            r_kind     <= KIND_AAD;
            r_last     <= 1'b0;
            r_aad      <= '0;
            r_plain    <= '0;
            r_size_out <= '0;
        end else if (w_out_free) begin
            if (w_data_hs) begin
                r_signal   <= 1'b1;
                r_kind     <= (r_state == S_AAD) ? KIND_AAD : KIND_TEXT;
                r_last     <= 1'b0;
                r_aad      <= (r_state == S_AAD) ? w_block : '0;
                r_plain    <= (r_state == S_TEXT) ? w_block : '0;
                r_size_out <= r_inst_size;
            end else if (r_state == S_LEN) begin
                r_signal   <= 1'b1;
                r_kind     <= KIND_LEN;
                r_last     <= 1'b1;
                r_aad      <= '0;
                r_plain    <= '0;
                r_size_out <= r_inst_size;
            end else begin
                r_signal <= 1'b0;
            end
        end
    end

    assign o_signal        = r_signal;
    assign o_kind          = r_kind;
    assign o_last          = r_last;
    assign o_aad           = r_aad;
    assign o_plain_text    = r_plain;
    assign o_instance_size = r_size_out;

`ifdef AES_GCM_SEQ_PERF_EN
    logic [31:0] r_inst_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst_count  <= '0;
            r_stall_count <= '0;
        end else begin
            if (r_signal && i_ready && r_last) r_inst_count <= r_inst_count + 32'd1;
            if (r_signal && !i_ready)          r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign o_inst_count  = r_inst_count;
    assign o_stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_aes_gcm_input_sequencer.sv
// Scoreboard bench for aes_gcm_input_sequencer: directed instances push expected
// beats; a negedge monitor pops and compares each accepted output beat.
module tb_aes_gcm_input_sequencer;

    logic         clk;
    logic         rst_n;
    logic         i_desc_valid;
    logic         o_desc_ready;
    logic [31:0]  i_aad_len;
    logic [31:0]  i_text_len;
    logic [0:127] i_data;
    logic         i_data_valid;
    logic         o_data_ready;
    logic         o_signal;
    logic         i_ready;
    logic [0:127] o_aad;
    logic [0:127] o_plain_text;
    logic [0:127] o_instance_size;
    logic [1:0]   o_kind;
    logic         o_last;
`ifdef AES_GCM_SEQ_PERF_EN
    logic [31:0]  o_inst_count;
    logic [31:0]  o_stall_count;
`endif

    aes_gcm_input_sequencer #(.LEN_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_desc_valid    (i_desc_valid),
        .o_desc_ready    (o_desc_ready),
        .i_aad_len       (i_aad_len),
        .i_text_len      (i_text_len),
        .i_data          (i_data),
        .i_data_valid    (i_data_valid),
        .o_data_ready    (o_data_ready),
        .o_signal        (o_signal),
        .i_ready         (i_ready),
        .o_aad           (o_aad),
        .o_plain_text    (o_plain_text),
        .o_instance_size (o_instance_size),
        .o_kind          (o_kind),
        .o_last          (o_last)
`ifdef AES_GCM_SEQ_PERF_EN
        ,
        .o_inst_count    (o_inst_count),
        .o_stall_count   (o_stall_count)
`endif
    );

    typedef struct {
        logic [1:0]   kind;
        logic         last;
        logic [0:127] aad;
        logic [0:127] plain;
        logic [0:127] size;
    } beat_t;

    beat_t exp_q[$];
    int    hs_cyc[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic last, input logic [0:127] aad,
                            input logic [0:127] plain, input logic [0:127] size);
        beat_t e;
        e.kind = kind; e.last = last; e.aad = aad; e.plain = plain; e.size = size;
        exp_q.push_back(e);
    endtask

    // Monitor: inputs only change just after posedge, so negedge sees the
    // values that the coming posedge will act upon.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && o_signal && i_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat: got unexpected beat kind %0d last %0d, required none", o_kind, o_last);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    hs_cyc.push_back(cyc);
                    if ({o_kind, o_last, o_aad, o_plain_text, o_instance_size} !==
                        {e.kind, e.last, e.aad, e.plain, e.size}) begin
                        n_fail++;
                        $display("FAIL beat: got k%0d l%0d a=%h p=%h s=%h required k%0d l%0d a=%h p=%h s=%h",
                                 o_kind, o_last, o_aad, o_plain_text, o_instance_size,
                                 e.kind, e.last, e.aad, e.plain, e.size);
                    end else begin
                        $display("[TB] beat k%0d l%0d a=%h p=%h s=%h", o_kind, o_last, o_aad, o_plain_text, o_instance_size);
                    end
                end
            end
        end
    end

    task automatic send_desc(input logic [31:0] aad_len, input logic [31:0] text_len);
        bit done = 0;
        i_desc_valid = 1'b1; i_aad_len = aad_len; i_text_len = text_len;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = o_desc_ready;
            @(posedge clk); #1;
        end
        i_desc_valid = 1'b0;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL desc_timeout: got no o_desc_ready, required handshake");
        end
    endtask

    task automatic send_block(input logic [0:127] data);
        bit done = 0;
        i_data_valid = 1'b1; i_data = data;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = o_data_ready;
            @(posedge clk); #1;
        end
        i_data_valid = 1'b0;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL data_timeout: got no o_data_ready, required handshake");
        end
    endtask

    task automatic drain(input bit no_data_ready);
        bit seen_ready = 0;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            if (o_data_ready) seen_ready = 1;
            @(posedge clk); #2;
        end
        @(posedge clk); #1;
        check("drain_queue_left", 128'(exp_q.size()), 128'd0);
        if (no_data_ready) check("data_ready_never", 128'(seen_ready), 128'd0);
    endtask

    logic [0:127] snap_out;
    logic [0:127] snap_now;

    initial begin
        rst_n = 1'b0; i_ready = 1'b1; i_desc_valid = 1'b0; i_data_valid = 1'b0;
        i_aad_len = '0; i_text_len = '0; i_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_signal", 128'(o_signal), 128'd0);
        check("rst_desc_ready", 128'(o_desc_ready), 128'd1);
        check("rst_data_ready", 128'(o_data_ready), 128'd0);
        check("rst_instance_size", o_instance_size, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // aad 16, text 32: AAD, TEXT, TEXT, LEN back to back
        hs_cyc.delete();
        send_desc(32'd16, 32'd32);
        push_exp(2'd0, 1'b0, 128'h00112233445566778899AABBCCDDEEFF, 128'h0, {64'h80, 64'h100});
        send_block(128'h00112233445566778899AABBCCDDEEFF);
        push_exp(2'd1, 1'b0, 128'h0, 128'h0F0E0D0C0B0A09080706050403020100, {64'h80, 64'h100});
        send_block(128'h0F0E0D0C0B0A09080706050403020100);
        push_exp(2'd1, 1'b0, 128'h0, 128'hDEADBEEFCAFEBABE0123456789ABCDEF, {64'h80, 64'h100});
        send_block(128'hDEADBEEFCAFEBABE0123456789ABCDEF);
        push_exp(2'd2, 1'b1, 128'h0, 128'h0, {64'h80, 64'h100});
        drain(1'b0);
        check("t1_beat_count", 128'(hs_cyc.size()), 128'd4);
        if (hs_cyc.size() == 4) check("t1_consecutive", 128'(hs_cyc[3] - hs_cyc[0]), 128'd3);

        // aad 0, text 20: second text block keeps bytes 0..3 only
        send_desc(32'd0, 32'd20);
        push_exp(2'd1, 1'b0, 128'h0, 128'h11111111222222223333333344444444, {64'h0, 64'd160});
        send_block(128'h11111111222222223333333344444444);
        push_exp(2'd1, 1'b0, 128'h0, 128'hFFFFFFFF000000000000000000000000, {64'h0, 64'd160});
        send_block({128{1'b1}});
        push_exp(2'd2, 1'b1, 128'h0, 128'h0, {64'h0, 64'd160});
        drain(1'b0);

        // empty instance: only the LEN beat, data never requested
        send_desc(32'd0, 32'd0);
        push_exp(2'd2, 1'b1, 128'h0, 128'h0, 128'h0);
        drain(1'b1);

        // back-pressure for 5 cycles after the first of 3 text beats
        send_desc(32'd0, 32'd48);
        push_exp(2'd1, 1'b0, 128'h0, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, {64'h0, 64'h180});
        send_block(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
        i_ready = 1'b0;
        i_data_valid = 1'b1; i_data = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
        snap_out = o_plain_text;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            snap_now = o_plain_text;
            check("stall_data_ready", 128'(o_data_ready), 128'd0);
            check("stall_hold", {126'(snap_now), o_signal, o_last}, {126'(snap_out), 1'b1, 1'b0});
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        i_data_valid = 1'b0;
        push_exp(2'd1, 1'b0, 128'h0, 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF, {64'h0, 64'h180});
        send_block(128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF);
        push_exp(2'd1, 1'b0, 128'h0, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF, {64'h0, 64'h180});
        send_block(128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
        push_exp(2'd2, 1'b1, 128'h0, 128'h0, {64'h0, 64'h180});
        drain(1'b0);
`ifdef AES_GCM_SEQ_PERF_EN
        check("stall_count", 128'(o_stall_count), 128'd5);
        check("inst_count_pre", 128'(o_inst_count), 128'd4);
`endif

        // reset after 1 of 3 text beats abandons the instance
        send_desc(32'd0, 32'd48);
        push_exp(2'd1, 1'b0, 128'h0, 128'h0102030405060708090A0B0C0D0E0F10, {64'h0, 64'h180});
        send_block(128'h0102030405060708090A0B0C0D0E0F10);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("arst_signal", 128'(o_signal), 128'd0);
        check("arst_outputs", {o_kind, o_last, 125'(o_plain_text)}, 128'd0);
        check("arst_instance_size", o_instance_size, 128'd0);
        check("arst_ready", {o_desc_ready, o_data_ready}, 128'd2);
`ifdef AES_GCM_SEQ_PERF_EN
        check("arst_inst_count", 128'(o_inst_count), 128'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // aad 5, text 17: masked AAD block, full text block, 1-byte text block
        send_desc(32'd5, 32'd17);
        push_exp(2'd0, 1'b0, 128'h01020304050000000000000000000000, 128'h0, {64'h28, 64'h88});
        send_block(128'h0102030405060708090A0B0C0D0E0F10);
        push_exp(2'd1, 1'b0, 128'h0, 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A, {64'h28, 64'h88});
        send_block(128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A);
        push_exp(2'd1, 1'b0, 128'h0, 128'hFF000000000000000000000000000000, {64'h28, 64'h88});
        send_block({128{1'b1}});
        push_exp(2'd2, 1'b1, 128'h0, 128'h0, {64'h28, 64'h88});
        drain(1'b0);
`ifdef AES_GCM_SEQ_PERF_EN
        check("inst_count_post", 128'(o_inst_count), 128'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
